// File: rtl/mmss_stopwatch.sv
// MM:SS up/down stopwatch-timer with BCD preset, countdown DONE and wrap pulse,
// driving four active-low 7-segment digits. Optional macro: LEAD_BLANK_EN.
module mmss_stopwatch #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned MAX_MIN = 59
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START_STOP,
    input  logic        CLEAR,
    input  logic        LOAD,
    input  logic [15:0] LD_VAL,
    input  logic        MODE,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        RUNNING,
    output logic        DONE,
    output logic        WRAP
);

    localparam int unsigned PERIOD = CLK_HZ / TICK_HZ;
    localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PERIOD - 1);
    localparam logic [3:0] MAX_M10 = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_M1  = 4'(MAX_MIN % 10);
    localparam logic [15:0] MAX_CNT = {MAX_M10, MAX_M1, 4'd5, 4'd9};
    localparam logic [6:0] SEG_ZERO  = 7'b100_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_nxt;
    logic [PW-1:0] presc_q, presc_nxt;
    logic [15:0]   cnt_q, cnt_nxt;
    logic          mode_q, mode_nxt;
    logic          wrap_nxt, running_nxt, done_nxt;
    logic [15:0]   inc_c, dec_c;
    logic [6:0]    ld_min_c;
    logic          tick_c, cnt_zero_c, load_ok_c, load_acc_c;
    logic [6:0]    hex0_nxt, hex1_nxt, hex2_nxt, hex3_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Qualifiers shared by the FSM and the datapath
    always_comb begin : qualifiers
        tick_c     = (state_q == S_RUN) && (presc_q == PRESC_LAST);
        cnt_zero_c = (cnt_q == 16'h0000);
        ld_min_c   = 7'(LD_VAL[15:12]) * 7'd10 + 7'(LD_VAL[11:8]);
        load_ok_c  = (LD_VAL[3:0] <= 4'd9) && (LD_VAL[7:4] <= 4'd5) &&
                     (LD_VAL[11:8] <= 4'd9) && (LD_VAL[15:12] <= 4'd9) &&
                     (ld_min_c <= 7'(MAX_MIN));
        load_acc_c = LOAD && load_ok_c && (state_q != S_RUN);
    end

    // BCD increment / decrement with carry and borrow chains
    always_comb begin : bcd_step
        inc_c = cnt_q;
        if (cnt_q[3:0] != 4'd9) begin
            inc_c[3:0] = cnt_q[3:0] + 4'd1;
        end else begin
            inc_c[3:0] = 4'd0;
            if (cnt_q[7:4] != 4'd5) begin
                inc_c[7:4] = cnt_q[7:4] + 4'd1;
            end else begin
                inc_c[7:4] = 4'd0;
                if (cnt_q[11:8] != 4'd9) begin
                    inc_c[11:8] = cnt_q[11:8] + 4'd1;
                end else begin
                    inc_c[11:8]  = 4'd0;
                    inc_c[15:12] = cnt_q[15:12] + 4'd1;
                end
            end
        end

        dec_c = cnt_q;
        if (cnt_q[3:0] != 4'd0) begin
            dec_c[3:0] = cnt_q[3:0] - 4'd1;
        end else begin
            dec_c[3:0] = 4'd9;
            if (cnt_q[7:4] != 4'd0) begin
                dec_c[7:4] = cnt_q[7:4] - 4'd1;
            end else begin
                dec_c[7:4] = 4'd5;
                if (cnt_q[11:8] != 4'd0) begin
                    dec_c[11:8] = cnt_q[11:8] - 4'd1;
                end else begin
                    dec_c[11:8]  = 4'd9;
                    dec_c[15:12] = cnt_q[15:12] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin : state_reg
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    // Next state: CLEAR > LOAD > START_STOP > tick
    always_comb begin : fsm_next
        state_nxt = state_q;
        if (CLEAR) begin
            state_nxt = S_IDLE;
        end else if (load_acc_c) begin
            state_nxt = S_IDLE;
        end else if (START_STOP) begin
            case (state_q)
                S_IDLE:  state_nxt = (MODE && cnt_zero_c) ? S_IDLE : S_RUN;
                S_RUN:   state_nxt = S_IDLE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end else if (tick_c && mode_q && (cnt_q == 16'h0001)) begin
            state_nxt = S_DONE;
        end
    end

    always_comb begin : fsm_out
        running_nxt = 1'b0;
        done_nxt    = 1'b0;
        running_nxt = (state_nxt == S_RUN);
        done_nxt    = (state_nxt == S_DONE);
    end

    // Count, prescaler and direction updates under the same priority
    always_comb begin : count_next
        cnt_nxt   = cnt_q;
        presc_nxt = presc_q;
        mode_nxt  = mode_q;
        wrap_nxt  = 1'b0;
        if (CLEAR) begin
            cnt_nxt   = 16'h0000;
            presc_nxt = '0;
        end else if (load_acc_c) begin
            cnt_nxt   = LD_VAL;
            presc_nxt = '0;
        end else if (START_STOP) begin
            if ((state_q == S_IDLE) && (state_nxt == S_RUN)) begin
                presc_nxt = '0;
                mode_nxt  = MODE;
            end
        end else if (state_q == S_RUN) begin
            presc_nxt = tick_c ? '0 : presc_q + PW'(1);
            if (tick_c) begin
                if (!mode_q) begin
                    if (cnt_q == MAX_CNT) begin
                        cnt_nxt  = 16'h0000;
                        wrap_nxt = 1'b1;
                    end else begin
                        cnt_nxt = inc_c;
                    end
                end else if (!cnt_zero_c) begin
                    cnt_nxt = dec_c;
                end
            end
        end
    end

    always_comb begin : hex_next
        hex0_nxt = seg7(cnt_q[3:0]);
        hex1_nxt = seg7(cnt_q[7:4]);
        hex2_nxt = seg7(cnt_q[11:8]);
        hex3_nxt = seg7(cnt_q[15:12]);
`ifdef LEAD_BLANK_EN
        if (cnt_q[15:12] == 4'd0) begin
            hex3_nxt = SEG_BLANK;
            if (cnt_q[11:8] == 4'd0) hex2_nxt = SEG_BLANK;
        end
`else
        hex2_nxt = hex2_nxt;
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin : data_reg
        if (!RST_N) begin
            presc_q <= '0;
            cnt_q   <= 16'h0000;
            mode_q  <= 1'b0;
            RUNNING <= 1'b0;
            DONE    <= 1'b0;
            WRAP    <= 1'b0;
            HEX0    <= SEG_ZERO;
            HEX1    <= SEG_ZERO;
            HEX2    <= SEG_ZERO;
            HEX3    <= SEG_ZERO;
        end else begin
            presc_q <= presc_nxt;
            cnt_q   <= cnt_nxt;
            mode_q  <= mode_nxt;
            RUNNING <= running_nxt;
            DONE    <= done_nxt;
            WRAP    <= wrap_nxt;
            HEX0    <= hex0_nxt;
            HEX1    <= hex1_nxt;
            HEX2    <= hex2_nxt;
            HEX3    <= hex3_nxt;
        end
    end

endmodule

// File: tb/tb_mmss_stopwatch.sv
// Bench for mmss_stopwatch at CLK_HZ=10, TICK_HZ=1, MAX_MIN=59: vector table with
// an expected-value queue, plus hand sequences for wrap pulse and async reset.
module tb_mmss_stopwatch;

    logic        CLK;
    logic        RST_N;
    logic        START_STOP;
    logic        CLEAR;
    logic        LOAD;
    logic [15:0] LD_VAL;
    logic        MODE;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic        RUNNING, DONE, WRAP;

    mmss_stopwatch #(.CLK_HZ(10), .TICK_HZ(1), .MAX_MIN(59)) dut (
        .CLK(CLK), .RST_N(RST_N), .START_STOP(START_STOP), .CLEAR(CLEAR),
        .LOAD(LOAD), .LD_VAL(LD_VAL), .MODE(MODE),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .RUNNING(RUNNING), .DONE(DONE), .WRAP(WRAP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        ss;
        logic        clr;
        logic        ld;
        logic        mode;
        logic [15:0] ldv;
        logic [15:0] wt;
        logic [15:0] cnt;
        logic        run;
        logic        done;
    } vec_t;

    typedef struct packed {
        logic [27:0] hex;
        logic        run;
        logic        done;
    } exp_t;

    localparam logic [6:0] SEG [16] = '{
        7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
        7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
        7'b000_0000, 7'b001_0000, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f};
    localparam logic [27:0] HEX_RESET = {4{7'b100_0000}};

    vec_t vecs [40];
    int   nv;
    exp_t sb [$];
    int   n_cmp;
    int   n_err;

    function automatic logic [27:0] model_hex(input logic [15:0] c);
        logic [6:0] h3;
        logic [6:0] h2;
        h3 = SEG[c[15:12]];
        h2 = SEG[c[11:8]];
`ifdef LEAD_BLANK_EN
        if (c[15:12] == 4'd0) begin
            h3 = 7'h7f;
            if (c[11:8] == 4'd0) h2 = 7'h7f;
        end
`endif
        return {h3, h2, SEG[c[7:4]], SEG[c[3:0]]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ss, input logic clr, input logic ld, input logic mode,
                       input logic [15:0] ldv, input int wt, input logic [15:0] cnt,
                       input logic run, input logic done);
        vecs[nv] = '{ss, clr, ld, mode, ldv, 16'(wt), cnt, run, done};
        nv++;
    endtask

    // Called at a negedge: pulse for one edge, wait wt more edges, compare
    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        v = vecs[idx];
        START_STOP = v.ss;
        CLEAR      = v.clr;
        LOAD       = v.ld;
        LD_VAL     = v.ldv;
        MODE       = v.mode;
        sb.push_back('{model_hex(v.cnt), v.run, v.done});
        @(negedge CLK);
        START_STOP = 1'b0;
        CLEAR      = 1'b0;
        LOAD       = 1'b0;
        repeat (int'(v.wt)) @(negedge CLK);
        e = sb.pop_front();
        check($sformatf("vec%0d_hex", idx), 32'({HEX3, HEX2, HEX1, HEX0}), 32'(e.hex));
        check($sformatf("vec%0d_flags", idx), 32'({RUNNING, DONE, WRAP}),
              32'({e.run, e.done, 1'b0}));
    endtask

    task automatic run_range(input int a, input int b);
        for (int i = a; i <= b; i++) run_vec(i);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nv    = 0;
        RST_N = 1'b0;
        START_STOP = 1'b0;
        CLEAR = 1'b0;
        LOAD = 1'b0;
        LD_VAL = 16'h0000;
        MODE = 1'b0;

        //   ss clr ld mode ldv      wt   cnt      run done
        add(1, 0, 0, 0, 16'h0000, 101, 16'h0010, 1, 0); // 0 count 00:10
        add(1, 0, 0, 0, 16'h0000,   1, 16'h0010, 0, 0); // 1 stop
        add(0, 0, 1, 0, 16'h5958,   1, 16'h5958, 0, 0); // 2 preset
        add(1, 0, 0, 0, 16'h0000,  11, 16'h5959, 1, 0); // 3 up to 59:59
        add(1, 0, 0, 0, 16'h0000,   1, 16'h0000, 0, 0); // 4 stop after wrap
        add(0, 0, 1, 0, 16'h0002,   1, 16'h0002, 0, 0); // 5
        add(1, 0, 0, 1, 16'h0000,  11, 16'h0001, 1, 0); // 6 countdown
        add(0, 0, 0, 1, 16'h0000,  20, 16'h0000, 0, 1); // 7 DONE holds
        add(1, 0, 0, 1, 16'h0000,   1, 16'h0000, 0, 0); // 8 DONE -> IDLE
        add(1, 0, 0, 1, 16'h0000,   1, 16'h0000, 0, 0); // 9 down at 00:00 refused
        add(0, 0, 1, 0, 16'h0123,   1, 16'h0123, 0, 0); // 10
        add(0, 0, 1, 0, 16'h0070,   1, 16'h0123, 0, 0); // 11 sec10 > 5
        add(0, 0, 1, 0, 16'h6000,   1, 16'h0123, 0, 0); // 12 minutes > 59
        add(0, 0, 1, 0, 16'h0A00,   1, 16'h0123, 0, 0); // 13 digit > 9
        add(0, 1, 1, 0, 16'h0123,   1, 16'h0000, 0, 0); // 14 CLEAR beats LOAD
        add(1, 0, 0, 0, 16'h0000,  14, 16'h0001, 1, 0); // 15
        add(1, 0, 0, 0, 16'h0000,  50, 16'h0001, 0, 0); // 16 stop mid-period
        add(1, 0, 0, 0, 16'h0000,   9, 16'h0001, 1, 0); // 17 prescaler restarted
        add(0, 0, 0, 0, 16'h0000,   1, 16'h0002, 1, 0); // 18
        add(1, 0, 0, 0, 16'h0000,   1, 16'h0002, 0, 0); // 19
        add(0, 0, 1, 0, 16'h0327,   1, 16'h0327, 0, 0); // 20
        add(1, 0, 0, 0, 16'h0000,   3, 16'h0327, 1, 0); // 21 running at 03:27
        add(0, 0, 1, 0, 16'h0005,   1, 16'h0005, 0, 0); // 22
        add(0, 0, 1, 0, 16'h0105,   1, 16'h0105, 0, 0); // 23
        add(0, 0, 1, 0, 16'h0959,   1, 16'h0959, 0, 0); // 24
        add(1, 0, 0, 0, 16'h0000,  11, 16'h1000, 1, 0); // 25 carry into min10
        add(1, 0, 0, 0, 16'h0000,   1, 16'h1000, 0, 0); // 26
        add(1, 0, 0, 1, 16'h0000,  11, 16'h0959, 1, 0); // 27 borrow from min10
        add(0, 0, 1, 1, 16'h0123,   1, 16'h0959, 1, 0); // 28 LOAD ignored in RUN
        add(0, 1, 0, 1, 16'h0000,   1, 16'h0000, 0, 0); // 29 CLEAR stops
        add(0, 0, 1, 1, 16'h5900,   1, 16'h5900, 0, 0); // 30
        add(1, 0, 0, 1, 16'h0000,  11, 16'h5859, 1, 0); // 31 59:00 -> 58:59
        add(0, 1, 0, 0, 16'h0000,   1, 16'h0000, 0, 0); // 32

        repeat (3) @(negedge CLK);
        check("reset_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(HEX_RESET));
        check("reset_flags", 32'({RUNNING, DONE, WRAP}), 32'(3'b000));
        RST_N = 1'b1;

        run_range(0, 3);
        // Wrap pulse: tick at 59:59 lands 9 edges after the last sample
        repeat (8) @(negedge CLK);
        check("wrap_before", 32'(WRAP), 32'(1'b0));
        @(negedge CLK);
        check("wrap_pulse", 32'(WRAP), 32'(1'b1));
        check("wrap_hex_lag", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(model_hex(16'h5959)));
        @(negedge CLK);
        check("wrap_after", 32'(WRAP), 32'(1'b0));
        check("wrap_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(model_hex(16'h0000)));
        check("wrap_running", 32'(RUNNING), 32'(1'b1));

        run_range(4, 21);
        // Asynchronous reset between clock edges while running
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(HEX_RESET));
        check("async_rst_flags", 32'({RUNNING, DONE, WRAP}), 32'(3'b000));
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        check("post_rst_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'(model_hex(16'h0000)));
        check("post_rst_flags", 32'({RUNNING, DONE, WRAP}), 32'(3'b000));

        run_range(22, nv - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
